fpalu_seq: RTL and testbench

- Latency-aware sequencer that wraps the pipelined single-precision FP cores (add/sub, mul, div, sqrt, compare, convert) behind a valid/ready handshake.
- Per-operation latencies are parameters; the block counts them and returns one result per request with a valid pulse.
- Executes neg/sign-injection ops internally and reports RISC-V style exception flags.
- Sits between the FP decode/issue stage and the FP register-file writeback.

---
 rtl/fpalu_seq_pkg.sv | 41 ++++
 rtl/fpalu_seq_if.sv | 35 +++
 rtl/fpalu_seq_lat.sv | 37 +++
 rtl/fpalu_seq.sv | 145 ++++++++++++++
 tb/tb_fpalu_seq.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpalu_seq_pkg.sv
// Shared opcodes, flag bit positions, FSM encoding and default latencies for the FP sequencer.
package fpalu_seq_pkg;

    localparam logic [4:0] FOPADD    = 5'd0;
    localparam logic [4:0] FOPSUB    = 5'd1;
    localparam logic [4:0] FOPMUL    = 5'd2;
    localparam logic [4:0] FOPDIV    = 5'd3;
    localparam logic [4:0] FOPSQRT   = 5'd4;
    localparam logic [4:0] FOPCEQ    = 5'd5;
    localparam logic [4:0] FOPCLT    = 5'd6;
    localparam logic [4:0] FOPCLE    = 5'd7;
    localparam logic [4:0] FOPCVTSW  = 5'd8;
    localparam logic [4:0] FOPCVTWS  = 5'd9;
    localparam logic [4:0] FOPABS    = 5'd10;
    localparam logic [4:0] FOPNEG    = 5'd11;
    localparam logic [4:0] FOPSIGNJ  = 5'd12;
    localparam logic [4:0] FOPSIGNJN = 5'd13;
    localparam logic [4:0] FOPSIGNJX = 5'd14;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int DEF_LAT_ADD  = 7;
    localparam int DEF_LAT_MUL  = 5;
    localparam int DEF_LAT_DIV  = 6;
    localparam int DEF_LAT_SQRT = 16;
    localparam int DEF_LAT_CMP  = 1;
    localparam int DEF_LAT_CVT  = 6;
    localparam int DEF_CNT_W    = 5;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    // How the result is formed once the latency has elapsed.
    typedef enum logic [2:0] {
        K_CORE, K_CMP, K_NEG, K_ABS, K_SGNJ, K_SGNJN, K_SGNJX, K_ILL
    } kind_t;

endpackage

// File: rtl/fpalu_seq_if.sv
// Issue-side request/result handshake plus the operand/result bus to the FP cores.
interface fpalu_seq_if;
    logic        ivalid;
    logic        oready;
    logic [4:0]  icontrol;
    logic [31:0] idataa;
    logic [31:0] idatab;
    logic        iflush;
    logic        ovalid;
    logic        iready;
    logic [31:0] oresult;
    logic [4:0]  oflags;
    logic        oillegal;
    logic [31:0] ocore_a;
    logic [31:0] ocore_b;
    logic [4:0]  ocore_op;
    logic [31:0] icore_result;
    logic        icore_nan;
    logic        icore_zero;
    logic        icore_ovf;
    logic        icore_unf;
    logic        icore_cmp;

    modport slave (
        input  ivalid, icontrol, idataa, idatab, iflush, iready,
        input  icore_result, icore_nan, icore_zero, icore_ovf, icore_unf, icore_cmp,
        output oready, ovalid, oresult, oflags, oillegal, ocore_a, ocore_b, ocore_op
    );

    modport master (
        output ivalid, icontrol, idataa, idatab, iflush, iready,
        output icore_result, icore_nan, icore_zero, icore_ovf, icore_unf, icore_cmp,
        input  oready, ovalid, oresult, oflags, oillegal, ocore_a, ocore_b, ocore_op
    );
endinterface

// File: rtl/fpalu_seq_lat.sv
// Combinational opcode decode: latency counter preload (LAT-1) and result kind; zero latency paths.
module fpalu_seq_lat
    import fpalu_seq_pkg::*;
#(
    parameter int LAT_ADD  = DEF_LAT_ADD,
    parameter int LAT_MUL  = DEF_LAT_MUL,
    parameter int LAT_DIV  = DEF_LAT_DIV,
    parameter int LAT_SQRT = DEF_LAT_SQRT,
    parameter int LAT_CMP  = DEF_LAT_CMP,
    parameter int LAT_CVT  = DEF_LAT_CVT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic [4:0]       i_op,
    output logic [CNT_W-1:0] o_cnt_init,
    output kind_t            o_kind
);
    always_comb begin
        o_cnt_init = '0;
        o_kind     = K_ILL;
        case (i_op)
            FOPADD, FOPSUB: begin o_cnt_init = CNT_W'(LAT_ADD - 1);  o_kind = K_CORE; end
            FOPMUL:         begin o_cnt_init = CNT_W'(LAT_MUL - 1);  o_kind = K_CORE; end
            FOPDIV:         begin o_cnt_init = CNT_W'(LAT_DIV - 1);  o_kind = K_CORE; end
            FOPSQRT:        begin o_cnt_init = CNT_W'(LAT_SQRT - 1); o_kind = K_CORE; end
            FOPCEQ, FOPCLT, FOPCLE:
                            begin o_cnt_init = CNT_W'(LAT_CMP - 1);  o_kind = K_CMP;  end
            FOPCVTSW, FOPCVTWS:
                            begin o_cnt_init = CNT_W'(LAT_CVT - 1);  o_kind = K_CORE; end
            FOPABS:         o_kind = K_ABS;
            FOPNEG:         o_kind = K_NEG;
            FOPSIGNJ:       o_kind = K_SGNJ;
            FOPSIGNJN:      o_kind = K_SGNJN;
            FOPSIGNJX:      o_kind = K_SGNJX;
            default:        o_kind = K_ILL;
        endcase
    end
endmodule

// File: rtl/fpalu_seq.sv
// One-op-in-flight FP sequencer: result valid LAT(op) cycles after accept, held until iready; oready only in IDLE.
// Optional FPALU_SEQ_STICKY_FLAGS_EN adds iflags_clr/osticky accumulation of consumed flags.
module fpalu_seq
    import fpalu_seq_pkg::*;
#(
    parameter int LAT_ADD  = DEF_LAT_ADD,
    parameter int LAT_MUL  = DEF_LAT_MUL,
    parameter int LAT_DIV  = DEF_LAT_DIV,
    parameter int LAT_SQRT = DEF_LAT_SQRT,
    parameter int LAT_CMP  = DEF_LAT_CMP,
    parameter int LAT_CVT  = DEF_LAT_CVT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic        iclock,
    input  logic        ireset_n,
    fpalu_seq_if.slave  bus
`ifdef FPALU_SEQ_STICKY_FLAGS_EN
    ,
    input  logic        iflags_clr,
    output logic [4:0]  osticky
`endif
);
    state_t           r_state;
    kind_t            r_kind;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_a, r_b, r_result;
    logic [4:0]       r_op, r_flags;
    logic             r_oready, r_ovalid, r_oillegal;

    logic [CNT_W-1:0] w_cnt_init;
    kind_t            w_kind;
    logic [31:0]      w_result;
    logic [4:0]       w_flags;
    logic             w_dz;
    logic             w_unused_zero;

    fpalu_seq_lat #(
        .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV), .LAT_SQRT(LAT_SQRT),
        .LAT_CMP(LAT_CMP), .LAT_CVT(LAT_CVT), .CNT_W(CNT_W)
    ) u_lat (
        .i_op      (bus.icontrol),
        .o_cnt_init(w_cnt_init),
        .o_kind    (w_kind)
    );

    assign w_unused_zero = bus.icore_zero;
    // Divide-by-zero only when the dividend is a finite nonzero number.
    assign w_dz = (r_op == FOPDIV) && (r_b[30:0] == 31'd0) &&
                  (r_a[30:23] != 8'hFF) && (r_a[30:0] != 31'd0);

    always_comb begin
        w_result = '0;
        w_flags  = '0;
        case (r_kind)
            K_CORE, K_CMP: begin
                w_result         = (r_kind == K_CMP) ? {31'd0, bus.icore_cmp} : bus.icore_result;
                w_flags[FLAG_NV] = bus.icore_nan;
                w_flags[FLAG_DZ] = w_dz;
                w_flags[FLAG_OF] = bus.icore_ovf;
                w_flags[FLAG_UF] = bus.icore_unf;
            end
            K_NEG:   w_result = {~r_a[31], r_a[30:0]};
            K_ABS:   w_result = {1'b0, r_a[30:0]};
            K_SGNJ:  w_result = {r_b[31], r_a[30:0]};
            K_SGNJN: w_result = {~r_b[31], r_a[30:0]};
            K_SGNJX: w_result = {r_a[31] ^ r_b[31], r_a[30:0]};
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n) begin
            r_state    <= ST_IDLE;
            r_kind     <= K_CORE;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_result   <= '0;
            r_flags    <= '0;
            r_oready   <= 1'b1;
            r_ovalid   <= 1'b0;
            r_oillegal <= 1'b0;
        end else if (bus.iflush) begin
            // Result and flags are left untouched; only the handshake state unwinds.
            r_state    <= ST_IDLE;
            r_oready   <= 1'b1;
            r_ovalid   <= 1'b0;
            r_oillegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.ivalid) begin
                    r_a      <= bus.idataa;
                    r_b      <= bus.idatab;
                    r_op     <= bus.icontrol;
                    r_kind   <= w_kind;
                    r_cnt    <= w_cnt_init;
                    r_oready <= 1'b0;
                    r_state  <= ST_BUSY;
                end
                ST_BUSY: if (r_cnt == '0) begin
                    r_result   <= w_result;
                    r_flags    <= w_flags;
                    r_oillegal <= (r_kind == K_ILL);
                    r_ovalid   <= 1'b1;
                    r_state    <= ST_DONE;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                ST_DONE: if (bus.iready) begin
                    r_ovalid   <= 1'b0;
                    r_oillegal <= 1'b0;
                    r_oready   <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.oready   = r_oready;
    assign bus.ovalid   = r_ovalid;
    assign bus.oresult  = r_result;
    assign bus.oflags   = r_flags;
    assign bus.oillegal = r_oillegal;
    assign bus.ocore_a  = r_a;
    assign bus.ocore_b  = r_b;
    assign bus.ocore_op = r_op;

`ifdef FPALU_SEQ_STICKY_FLAGS_EN
    logic [4:0] r_sticky;
    logic       w_hs;

    assign w_hs = r_ovalid & bus.iready & ~bus.iflush;

    // Clear takes effect before the OR so a coincident handshake's flags survive.
    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n) r_sticky <= '0;
        else           r_sticky <= (iflags_clr ? 5'd0 : r_sticky) | (w_hs ? r_flags : 5'd0);
    end

    assign osticky = r_sticky;
`endif

endmodule

// File: tb/tb_fpalu_seq.sv
// Directed-vector bench for fpalu_seq: driver pushes expected results, negedge monitor compares on ovalid.
module tb_fpalu_seq;
    import fpalu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpalu_seq_if bus();

`ifdef FPALU_SEQ_STICKY_FLAGS_EN
    logic       flags_clr = 1'b0;
    logic [4:0] sticky;
`endif

    fpalu_seq dut (
        .iclock  (clk),
        .ireset_n(rst_n),
        .bus     (bus.slave)
`ifdef FPALU_SEQ_STICKY_FLAGS_EN
        ,
        .iflags_clr(flags_clr),
        .osticky   (sticky)
`endif
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   pend_at = -100;
    bit   seen = 1'b0;

    logic [31:0] c_res;
    logic        c_nan, c_ovf, c_unf, c_cmp;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Core model: real values appear only in the cycle the sequencer should capture them.
    always @(posedge clk) begin
        #1;
        if (cyc == pend_at) begin
            bus.icore_result = c_res;
            bus.icore_nan    = c_nan;
            bus.icore_zero   = 1'b0;
            bus.icore_ovf    = c_ovf;
            bus.icore_unf    = c_unf;
            bus.icore_cmp    = c_cmp;
        end else begin
            bus.icore_result = 32'hDEADBEEF;
            bus.icore_nan    = 1'b1;
            bus.icore_zero   = 1'b1;
            bus.icore_ovf    = 1'b1;
            bus.icore_unf    = 1'b1;
            bus.icore_cmp    = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.ovalid) begin
            if (q.size() == 0) begin
                chk("unexpected_ovalid", {31'd0, bus.ovalid}, 32'd0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                end
                chk("oresult", bus.oresult, q[0].res);
                chk("oflags", {27'd0, bus.oflags}, {27'd0, q[0].flg});
                chk("oillegal", {31'd0, bus.oillegal}, {31'd0, q[0].ill});
                chk("oready_in_done", {31'd0, bus.oready}, 32'd0);
                if (bus.iready && !bus.iflush) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] cres, input logic nan,
                         input logic ovf, input logic unf, input logic cmp,
                         input logic [31:0] eres, input logic [4:0] eflg, input logic eill,
                         input bit push);
        int t = 0;
        while (!bus.oready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.oready) begin
            chk("issue_timeout", {31'd0, bus.oready}, 32'd1);
            return;
        end
        c_res = cres; c_nan = nan; c_ovf = ovf; c_unf = unf; c_cmp = cmp;
        pend_at = cyc + lat;
        bus.ivalid   = 1'b1;
        bus.icontrol = op;
        bus.idataa   = a;
        bus.idatab   = b;
        if (push) q.push_back('{eres, eflg, eill, cyc + 1, lat});
        @(posedge clk); #1;
        bus.ivalid = 1'b0;
        last_acc   = cyc;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int h;
        bus.ivalid = 1'b0; bus.icontrol = '0; bus.idataa = '0; bus.idatab = '0;
        bus.iflush = 1'b0; bus.iready = 1'b1;
        #12;
        chk("rst_oready", {31'd0, bus.oready}, 32'd1);
        chk("rst_ovalid", {31'd0, bus.ovalid}, 32'd0);
        chk("rst_oresult", bus.oresult, 32'd0);
        chk("rst_oflags", {27'd0, bus.oflags}, 32'd0);
        chk("rst_oillegal", {31'd0, bus.oillegal}, 32'd0);
        chk("rst_ocore_a", bus.ocore_a, 32'd0);
        chk("rst_ocore_op", {27'd0, bus.ocore_op}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        issue(FOPADD, 32'h3F800000, 32'h40000000, 7, 32'h40400000, 0, 0, 0, 0,
              32'h40400000, 5'b00000, 0, 1);
        chk("ocore_a", bus.ocore_a, 32'h3F800000);
        chk("ocore_b", bus.ocore_b, 32'h40000000);
        issue(FOPSIGNJN, 32'h3F800000, 32'h80000000, 1, 32'h0, 0, 0, 0, 0,
              32'h3F800000, 5'b00000, 0, 1);
        issue(FOPDIV, 32'h3F800000, 32'h00000000, 6, 32'h7F800000, 0, 0, 0, 0,
              32'h7F800000, 5'b01000, 0, 1);
        drain();
`ifdef FPALU_SEQ_STICKY_FLAGS_EN
        chk("sticky_after_div", {27'd0, sticky}, 32'h08);
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        chk("sticky_cleared", {27'd0, sticky}, 32'h00);
`endif
        issue(FOPMUL, 32'h7F000000, 32'h40000000, 5, 32'h7F800000, 0, 1, 0, 0,
              32'h7F800000, 5'b00100, 0, 1);
        issue(FOPNEG, 32'h40490FDB, 32'h0, 1, 32'h0, 0, 0, 0, 0,
              32'hC0490FDB, 5'b00000, 0, 1);
        issue(FOPABS, 32'hC0000000, 32'h0, 1, 32'h0, 0, 0, 0, 0,
              32'h40000000, 5'b00000, 0, 1);
        issue(FOPSIGNJX, 32'hC0000000, 32'h80000000, 1, 32'h0, 0, 0, 0, 0,
              32'h40000000, 5'b00000, 0, 1);
        issue(FOPSIGNJ, 32'h3F800000, 32'h80000000, 1, 32'h0, 0, 0, 0, 0,
              32'hBF800000, 5'b00000, 0, 1);
        issue(FOPCLT, 32'h3F800000, 32'h40000000, 1, 32'h12345678, 0, 0, 0, 1,
              32'h00000001, 5'b00000, 0, 1);
        issue(FOPCVTSW, 32'h0000000A, 32'h0, 6, 32'h41200000, 0, 0, 0, 0,
              32'h41200000, 5'b00000, 0, 1);
        issue(5'h1F, 32'h12345678, 32'h9ABCDEF0, 1, 32'hFFFFFFFF, 1, 1, 1, 1,
              32'h00000000, 5'b00000, 1, 1);
        issue(FOPDIV, 32'h00000000, 32'h00000000, 6, 32'h7FC00000, 1, 0, 0, 0,
              32'h7FC00000, 5'b10000, 0, 1);
        drain();

        // Backpressure: hold the result in DONE, then release and reissue immediately.
        bus.iready = 1'b0;
        issue(FOPSUB, 32'h40400000, 32'h3F800000, 7, 32'h40000000, 0, 0, 0, 0,
              32'h40000000, 5'b00000, 0, 1);
        t = 0;
        while (!bus.ovalid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("bp_ovalid_seen", {31'd0, bus.ovalid}, 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("bp_ovalid_held", {31'd0, bus.ovalid}, 32'd1);
        bus.iready = 1'b1;
        @(posedge clk); #1;
        h = cyc;
        chk("bp_oready_after", {31'd0, bus.oready}, 32'd1);
        chk("bp_ovalid_after", {31'd0, bus.ovalid}, 32'd0);
        issue(FOPADD, 32'h3F800000, 32'h3F800000, 7, 32'h40000000, 0, 0, 0, 0,
              32'h40000000, 5'b00000, 0, 1);
        chk("bp_next_accept_cycle", 32'(last_acc), 32'(h + 1));
        drain();

        // Flush an in-flight SQRT on its third cycle, then a MUL must run normally.
        issue(FOPSQRT, 32'h40800000, 32'h0, 16, 32'h40000000, 0, 0, 0, 0,
              32'h0, 5'b00000, 0, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus.iflush = 1'b1;
        @(posedge clk); #1;
        bus.iflush = 1'b0;
        chk("flush_oready", {31'd0, bus.oready}, 32'd1);
        chk("flush_ovalid", {31'd0, bus.ovalid}, 32'd0);
        chk("flush_oresult_kept", bus.oresult, 32'h40000000);
        issue(FOPMUL, 32'h40000000, 32'h40400000, 5, 32'h40C00000, 0, 0, 0, 0,
              32'h40C00000, 5'b00000, 0, 1);
        drain();
        repeat (20) begin
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
